// File: rtl/fc_weight_streamer.sv
// rtl/fc_weight_streamer.sv - FC weight-load responder: grants a burst, reads weight memory, streams words back
module fc_weight_streamer #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned WORD_W = 128,
  parameter int unsigned CNT_W  = 11,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              weight_req,
  input  logic [ADDR_W-1:0] weight_base,
  input  logic [CNT_W-1:0]  weight_count,
  output logic              weight_grant,
  output logic              weight_valid,
  output logic [WORD_W-1:0] weight_data,
  output logic              weight_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    issued_q;
  logic [CNT_W-1:0]    returned_q;
  logic [RD_LAT-1:0]   vpipe_q;
  logic [RD_LAT-1:0]   vpipe_d;
  logic                grant_q;
  logic                valid_q;
  logic                done_q;
  logic                rd_en_q;
  logic                busy_q;
  logic [WORD_W-1:0]   data_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                accept;
  logic                tap;

  // The DONE cycle's exit edge doubles as the IDLE sampling point, so a held
  // request is granted in the cycle right after weight_done.
  assign accept = weight_req && ((state_q == IDLE) || (state_q == DONE));

  // A pipeline bit reaching the tap means mem_rd_data carries a word this cycle.
  assign tap = vpipe_q[RD_LAT-1];

  // Shift the issued-read strobe one stage towards the tap each cycle.
  always_comb begin
    vpipe_d    = vpipe_q << 1;
    vpipe_d[0] = rd_en_q;
  end

  // Burst FSM together with the read-issue and read-return datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      vpipe_q    <= '0;
      grant_q    <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= '0;
      rd_addr_q  <= '0;
    end else begin
      grant_q <= 1'b0;
      done_q  <= 1'b0;

      // Return path: capture each word as it arrives; data holds otherwise.
      vpipe_q <= vpipe_d;
      valid_q <= tap;
      if (tap) begin
        data_q     <= mem_rd_data;
        returned_q <= returned_q + 1'b1;
      end

      unique case (state_q)
        IDLE: begin
        end
        ISSUE: begin
          if (issued_q == count_q) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
            issued_q  <= issued_q + 1'b1;
          end
        end
        DRAIN: begin
          if (returned_q == count_q) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase

      // A zero-length burst goes through DRAIN, where returned==count already
      // holds, so done lands exactly one cycle after the grant.
      if (accept) begin
        count_q    <= weight_count;
        issued_q   <= CNT_W'(weight_count != '0);
        returned_q <= '0;
        rd_addr_q  <= weight_base;
        rd_en_q    <= (weight_count != '0);
        grant_q    <= 1'b1;
        busy_q     <= 1'b1;
        state_q    <= (weight_count != '0) ? ISSUE : DRAIN;
      end
    end
  end

  assign weight_grant = grant_q;
  assign weight_valid = valid_q;
  assign weight_data  = data_q;
  assign weight_done  = done_q;
  assign mem_rd_en    = rd_en_q;
  assign mem_rd_addr  = rd_addr_q;
  assign busy         = busy_q;

endmodule
